// File: rtl/seg7_capture_if.sv
// seg7_capture_if: the seven-segment receive bus.
//   digit_in / display_in : scanned active-low anode and segment lines from the display driver
//   nums / digit_valid / frame_valid / update / err : recovered digit state reported by the capture block
// master: whoever drives the pins and watches the results (board logic or testbench).
// slave : the capture block itself.
interface seg7_capture_if;
    logic [3:0]  digit_in;
    logic [6:0]  display_in;
    logic [15:0] nums;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        update;
    logic        err;

    modport master (
        output digit_in,
        output display_in,
        input  nums,
        input  digit_valid,
        input  frame_valid,
        input  update,
        input  err
    );

    modport slave (
        input  digit_in,
        input  display_in,
        output nums,
        output digit_valid,
        output frame_valid,
        output update,
        output err
    );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: receive side of the four-digit multiplexed seven-segment bus.
// Synchronises the asynchronous digit/display pair, waits for it to stay
// unchanged for SETTLE cycles, then decodes the segment pattern back to a
// 4-bit code and stores it in the nibble selected by the active anode.
//
// Parameters:
//   SETTLE : stable cycles required before sampling (1..255).
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : seg7_capture_if.slave
//         inputs  digit_in[3:0] (active-low anodes), display_in[6:0] ({g..a}, active-low)
//         outputs nums[15:0], digit_valid[3:0], frame_valid, update, err
// Optional build macro:
//   SEG7_CAPTURE_ERR_EN : invalid segment patterns are dropped and set the
//                         sticky err flag; otherwise they are stored as 4'hE
//                         and err is tied low.
module seg7_capture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg7_capture_if.slave  bus
);

    localparam int unsigned DIG_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NUMS_W     = NUM_DIGITS * CODE_W;

    // One sampled bus state: anodes above segments
    typedef struct packed {
        logic [DIG_W-1:0] digit;
        logic [SEG_W-1:0] display;
    } pair_t;

    pair_t               meta_q;
    pair_t               s_q;
    pair_t               p_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUMS_W-1:0]     nums_q;
    logic [NUM_DIGITS-1:0] valid_q;
    logic                  frame_q;
    logic                  update_q;

    logic                  strobe_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  idx_ok_c;
    logic [CODE_W-1:0]     code_raw_c;
    logic                  code_ok_c;
    logic [CODE_W-1:0]     wr_code_c;
    logic                  wr_c;
    logic [CODE_W-1:0]     old_code_c;
    logic                  changed_c;
    logic [NUMS_W-1:0]     nums_nxt_c;
    logic [NUM_DIGITS-1:0] valid_nxt_c;

    // Two-flop synchroniser plus one delayed copy for change detection.
    // Reset to all-ones so the idle state looks like a blanked display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '1;
            s_q    <= '1;
            p_q    <= '1;
        end else begin
            meta_q <= {bus.digit_in, bus.display_in};
            s_q    <= meta_q;
            p_q    <= s_q;
        end
    end

    // Settle counter: clears on any change, saturates at SETTLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (s_q != p_q) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(SETTLE)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Saturation makes this compare true on exactly one cycle per stable window
    assign strobe_c = (s_q == p_q) && (cnt_q == CNT_W'(SETTLE - 1));

    // Anode decode: only a single low line selects a digit
    always_comb begin
        idx_c    = '0;
        idx_ok_c = 1'b1;
        case (s_q.digit)
            4'b1110: idx_c = IDX_W'(0);
            4'b1101: idx_c = IDX_W'(1);
            4'b1011: idx_c = IDX_W'(2);
            4'b0111: idx_c = IDX_W'(3);
            default: idx_ok_c = 1'b0;
        endcase
    end

    // Segment decode, {g,f,e,d,c,b,a} active-low
    always_comb begin
        code_raw_c = '0;
        code_ok_c  = 1'b1;
        case (s_q.display)
            7'b1000000: code_raw_c = 4'h0;
            7'b1111001: code_raw_c = 4'h1;
            7'b0100100: code_raw_c = 4'h2;
            7'b0110000: code_raw_c = 4'h3;
            7'b0011001: code_raw_c = 4'h4;
            7'b0010010: code_raw_c = 4'h5;
            7'b0000010: code_raw_c = 4'h6;
            7'b1111000: code_raw_c = 4'h7;
            7'b0000000: code_raw_c = 4'h8;
            7'b0010000: code_raw_c = 4'h9;
            7'b1111111: code_raw_c = 4'hF;
            default:    code_ok_c  = 1'b0;
        endcase
    end

`ifdef SEG7_CAPTURE_ERR_EN
    logic err_q;

    // Invalid patterns are dropped and flagged
    assign wr_code_c = code_raw_c;
    assign wr_c      = strobe_c && idx_ok_c && code_ok_c;

    // Sticky error: any non-table pattern sampled on a selected digit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (strobe_c && idx_ok_c && !code_ok_c) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    // Invalid patterns are stored as 4'hE so the mirror shows something is off
    assign wr_code_c = code_ok_c ? code_raw_c : 4'hE;
    assign wr_c      = strobe_c && idx_ok_c;
    assign bus.err   = 1'b0;
`endif

    assign old_code_c = nums_q[{idx_c, 2'b00} +: CODE_W];
    assign changed_c  = (old_code_c != wr_code_c) || !valid_q[idx_c];

    // Next digit state; frame_valid follows the next-state valid bits so it
    // rises together with the last digit_valid bit
    always_comb begin
        nums_nxt_c  = nums_q;
        valid_nxt_c = valid_q;
        if (wr_c) begin
            nums_nxt_c[{idx_c, 2'b00} +: CODE_W] = wr_code_c;
            valid_nxt_c[idx_c]                   = 1'b1;
        end
    end

    // Captured digit state and change pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nums_q   <= '0;
            valid_q  <= '0;
            frame_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            nums_q   <= nums_nxt_c;
            valid_q  <= valid_nxt_c;
            frame_q  <= &valid_nxt_c;
            update_q <= wr_c && changed_c;
        end
    end

    assign bus.nums        = nums_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_valid = frame_q;
    assign bus.update      = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: randomized self-checking bench for seg7_capture.
// Pins are driven in "slots" (one pair held for a number of cycles); an
// abstract model decides per slot whether the pair is captured and what the
// visible digit state must be afterwards.
module tb_seg7_capture;

    localparam int unsigned SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seg7_capture_if bus ();

    seg7_capture #(.SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Seven-segment glyphs for 0..9, {g,f,e,d,c,b,a} active-low
    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    logic [3:0] anode_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reference model state
    logic [3:0] m_nums [4];
    logic [3:0] m_valid;
    logic       m_err;

    function automatic int seg_to_code(input logic [6:0] seg);
        for (int i = 0; i < 10; i++)
            if (seg_tbl[i] == seg) return i;
        if (seg == 7'h7F) return 15;
        return -1;
    endfunction

    function automatic int dig_to_idx(input logic [3:0] dig);
        for (int i = 0; i < 4; i++)
            if (anode_tbl[i] == dig) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_word();
        return {m_nums[3], m_nums[2], m_nums[1], m_nums[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nums[i] = 4'h0;
        m_valid = 4'b0000;
        m_err   = 1'b0;
    endtask

    // A slot held long enough is captured once; returns whether update must pulse
    task automatic model_apply(input logic [3:0] dig, input logic [6:0] seg,
                               input int len, output int exp_upd);
        int idx;
        int code;
        exp_upd = 0;
        if (len < int'(SETTLE) + 1) return;
        idx = dig_to_idx(dig);
        if (idx < 0) return;
        code = seg_to_code(seg);
        if (code < 0) begin
`ifdef SEG7_CAPTURE_ERR_EN
            m_err = 1'b1;
            return;
`else
            code = 14;
`endif
        end
        if (!m_valid[idx] || m_nums[idx] != 4'(code)) exp_upd = 1;
        m_nums[idx]  = 4'(code);
        m_valid[idx] = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".nums"},        32'(bus.nums),        32'(m_word()));
        check({tag, ".digit_valid"}, 32'(bus.digit_valid), 32'(m_valid));
        check({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(&m_valid));
        check({tag, ".err"},         32'(bus.err),         32'(m_err));
    endtask

    // Called and returns on a falling edge; holds the pair for len rising edges
    task automatic drive_slot(input logic [3:0] dig, input logic [6:0] seg,
                              input int len, input string tag);
        int upd_cnt = 0;
        int upd_at  = -1;
        int exp_upd;
        bus.digit_in   = dig;
        bus.display_in = seg;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (bus.update === 1'b1) begin
                upd_cnt++;
                if (upd_at < 0) upd_at = k;
            end
        end
        model_apply(dig, seg, len, exp_upd);
        check({tag, ".update_cnt"}, 32'(upd_cnt), 32'(exp_upd));
        if (exp_upd != 0)
            check({tag, ".update_edge"}, 32'(upd_at), 32'(SETTLE + 3));
        check_state(tag);
    endtask

    // Releases reset on a falling edge with the pair already at the pins and
    // checks the exact capture edge
    task automatic first_capture(input logic [3:0] dig, input logic [6:0] seg,
                                 input logic [15:0] exp_nums, input string tag);
        int exp_upd;
        model_reset();
        bus.digit_in   = dig;
        bus.display_in = seg;
        rst            = 1'b1;
        repeat (SETTLE + 2) @(negedge clk);
        check({tag, ".early_nums"},   32'(bus.nums),   32'h0);
        check({tag, ".early_update"}, 32'(bus.update), 32'h0);
        @(negedge clk);
        model_apply(dig, seg, 1000, exp_upd);
        check({tag, ".nums"},        32'(bus.nums),        32'(exp_nums));
        check({tag, ".model_nums"},  32'(bus.nums),        32'(m_word()));
        check({tag, ".digit_valid"}, 32'(bus.digit_valid), 32'(m_valid));
        check({tag, ".update"},      32'(bus.update),      32'(exp_upd));
        @(negedge clk);
        check({tag, ".update_fall"}, 32'(bus.update), 32'h0);
    endtask

    task automatic scan_1234(input string tag);
        drive_slot(4'b0111, seg_tbl[1], 20, {tag, ".d3"});
        drive_slot(4'b1011, seg_tbl[2], 20, {tag, ".d2"});
        drive_slot(4'b1101, seg_tbl[3], 20, {tag, ".d1"});
        drive_slot(4'b1110, seg_tbl[4], 20, {tag, ".d0"});
        check({tag, ".word"},  32'(bus.nums),        32'h1234);
        check({tag, ".frame"}, 32'(bus.frame_valid), 32'h1);
    endtask

    logic [3:0] last_dig;
    logic [6:0] last_seg;

    initial begin
        int r;
        int len;
        logic [3:0] dig;
        logic [6:0] seg;

        bus.digit_in   = 4'b1111;
        bus.display_in = 7'h7F;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.nums",        32'(bus.nums),        32'h0);
        check("reset.digit_valid", 32'(bus.digit_valid), 32'h0);
        check("reset.frame_valid", 32'(bus.frame_valid), 32'h0);
        check("reset.update",      32'(bus.update),      32'h0);
        check("reset.err",         32'(bus.err),         32'h0);

        first_capture(4'b1110, 7'b0110000, 16'h0003, "first");

        scan_1234("scan1");
        scan_1234("scan2");

        // Short glitch is dropped; the following pair gets a fresh window
        drive_slot(4'b1011, seg_tbl[7], 3, "glitch.a");
        drive_slot(4'b1011, seg_tbl[9], 20, "glitch.b");
        check("glitch.nibble", 32'(bus.nums[11:8]), 32'h9);

        // Blanked and multi-low anodes never write
        drive_slot(4'b1111, seg_tbl[0], 12, "anode.blank");
        drive_slot(4'b1100, seg_tbl[5], 12, "anode.multi");
        check("anode.word", 32'(bus.nums), 32'h1934);

        // Same pair held twice in a row: only one strobe
        drive_slot(4'b1101, 7'h7F, 15, "blank.d1");
        check("blank.nibble", 32'(bus.nums[7:4]), 32'hF);
        drive_slot(4'b1101, 7'h7F, 15, "blank.hold");

        drive_slot(4'b1101, 7'b0101010, 15, "bad.d1");
`ifdef SEG7_CAPTURE_ERR_EN
        check("bad.nibble", 32'(bus.nums[7:4]), 32'hF);
        check("bad.err",    32'(bus.err),       32'h1);
`else
        check("bad.nibble", 32'(bus.nums[7:4]), 32'hE);
        check("bad.err",    32'(bus.err),       32'h0);
`endif

        // Randomized slots; consecutive slots always differ so each window stands alone
        last_dig = 4'b1101;
        last_seg = 7'b0101010;
        for (int n = 0; n < 80; n++) begin
            do begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       dig = anode_tbl[$urandom_range(0, 3)];
                else if (r == 7) dig = 4'b1111;
                else if (r == 8) dig = 4'b1100;
                else             dig = 4'($urandom);
                r = int'($urandom_range(0, 11));
                if (r < 10)       seg = seg_tbl[r];
                else if (r == 10) seg = 7'h7F;
                else              seg = 7'($urandom);
            end while (dig == last_dig && seg == last_seg);
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, SETTLE));
            else                           len = int'($urandom_range(SETTLE + 4, SETTLE + 16));
            drive_slot(dig, seg, len, $sformatf("rand%0d", n));
            last_dig = dig;
            last_seg = seg;
        end

        // Reset in the middle of a scan slot clears everything at once
        scan_1234("scan3");
        bus.digit_in   = 4'b1011;
        bus.display_in = seg_tbl[6];
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst.nums",        32'(bus.nums),        32'h0);
        check("midrst.digit_valid", 32'(bus.digit_valid), 32'h0);
        check("midrst.frame_valid", 32'(bus.frame_valid), 32'h0);
        check("midrst.update",      32'(bus.update),      32'h0);
        check("midrst.err",         32'(bus.err),         32'h0);
        @(negedge clk);
        @(negedge clk);
        first_capture(4'b1101, seg_tbl[5], 16'h0050, "recap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
